// File: rtl/onchip_mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between Avalon-MM masters A and B; grant is combinational, reads return 1 cycle after acceptance.
// Backpressure: the losing requester sees waitrequest=1 and retries; both contending requesters strictly alternate.
module onchip_mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                mem_clken
);

  localparam int BE_W = DATA_W / 8;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wd;
  } req_t;

  req_t req_a_s;
  req_t req_b_s;
  req_t sel;
  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;
  logic last_grant;
  logic rd_pend;
  logic rd_owner;

  assign req_a_s = '{rd: a_read, wr: a_write, addr: a_address, be: a_byteenable, wd: a_writedata};
  assign req_b_s = '{rd: b_read, wr: b_write, addr: b_address, be: b_byteenable, wd: b_writedata};

  // Reset gates the grant directly so the RAM port is quiet the instant reset_n falls.
  always_comb begin
    req_a   = a_read | a_write;
    req_b   = b_read | b_write;
    grant_a = reset_n & req_a & (~req_b | last_grant);
    grant_b = reset_n & req_b & (~req_a | ~last_grant);
    sel     = grant_b ? req_b_s : req_a_s;
  end

  assign a_waitrequest  = req_a & ~grant_a;
  assign b_waitrequest  = req_b & ~grant_b;

  assign mem_chipselect = grant_a | grant_b;
  assign mem_write      = mem_chipselect & sel.wr;
  assign mem_address    = sel.addr;
  assign mem_byteenable = sel.be;
  assign mem_writedata  = sel.wd;
  assign mem_clken      = reset_n;

  // A combined read+write is a write, so it never produces a read return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (mem_chipselect) last_grant <= grant_b;
      rd_pend  <= mem_chipselect & sel.rd & ~sel.wr;
      rd_owner <= grant_b;
    end
  end

  assign a_readdatavalid = rd_pend & ~rd_owner;
  assign b_readdatavalid = rd_pend & rd_owner;
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// Directed-vector bench for onchip_mem_port_arbiter with a behavioural 256x32 RAM on the shared port.
module tb_onchip_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  a_address, b_address, mem_address;
  logic [3:0]  a_byteenable, b_byteenable, mem_byteenable;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata, mem_writedata;
  logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
  logic [31:0] a_readdata, b_readdata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;

  int checks = 0;
  int errors = 0;

  onchip_mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_clken(mem_clken)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, byte-lane writes
  logic [31:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h01] = 32'h11110001;
    ram[8'h02] = 32'h22220002;
    ram[8'hFF] = 32'hAAAAAAAA;
  end
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int j = 0; j < 4; j++)
          if (mem_byteenable[j]) ram[mem_address][j*8 +: 8] <= mem_writedata[j*8 +: 8];
      end
      mem_readdata <= ram[mem_address];
    end
  end

  typedef struct {
    logic       a_rd, a_wr; logic [7:0] a_addr; logic [3:0] a_be; logic [31:0] a_wd;
    logic       b_rd, b_wr; logic [7:0] b_addr; logic [3:0] b_be; logic [31:0] b_wd;
    logic       e_aw, e_bw, e_cs, e_we; logic [7:0] e_addr;
    logic       e_ardv, e_brdv; logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 20;
  vec_t v [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_read = 0; a_write = 0; a_address = 0; a_byteenable = 4'hF; a_writedata = 0;
    b_read = 0; b_write = 0; b_address = 0; b_byteenable = 4'hF; b_writedata = 0;
  endtask

  initial begin
    //        a_rd a_wr a_addr a_be a_wd          b_rd b_wr b_addr b_be b_wd          aw bw cs we addr  ardv brdv rdata
    v[0]  = '{1, 0, 8'h01, 4'hF, 32'h0,        1, 0, 8'h02, 4'hF, 32'h0,        0, 1, 1, 0, 8'h01, 0, 0, 32'h0};
    v[1]  = '{1, 0, 8'h01, 4'hF, 32'h0,        1, 0, 8'h02, 4'hF, 32'h0,        1, 0, 1, 0, 8'h02, 1, 0, 32'h11110001};
    v[2]  = '{1, 0, 8'h01, 4'hF, 32'h0,        1, 0, 8'h02, 4'hF, 32'h0,        0, 1, 1, 0, 8'h01, 0, 1, 32'h22220002};
    v[3]  = '{1, 0, 8'h01, 4'hF, 32'h0,        1, 0, 8'h02, 4'hF, 32'h0,        1, 0, 1, 0, 8'h02, 1, 0, 32'h11110001};
    v[4]  = '{1, 0, 8'h01, 4'hF, 32'h0,        1, 0, 8'h02, 4'hF, 32'h0,        0, 1, 1, 0, 8'h01, 0, 1, 32'h22220002};
    v[5]  = '{1, 0, 8'h01, 4'hF, 32'h0,        1, 0, 8'h02, 4'hF, 32'h0,        1, 0, 1, 0, 8'h02, 1, 0, 32'h11110001};
    v[6]  = '{0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 0, 0, 8'h00, 0, 1, 32'h22220002};
    v[7]  = '{0, 1, 8'h10, 4'hF, 32'hDEADBEEF, 0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 1, 1, 8'h10, 0, 0, 32'h0};
    v[8]  = '{1, 0, 8'h10, 4'hF, 32'h0,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 1, 0, 8'h10, 0, 0, 32'h0};
    v[9]  = '{0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 0, 0, 8'h00, 1, 0, 32'hDEADBEEF};
    v[10] = '{0, 0, 8'h00, 4'hF, 32'h0,        1, 0, 8'hFF, 4'hF, 32'h0,        0, 0, 1, 0, 8'hFF, 0, 0, 32'h0};
    v[11] = '{0, 0, 8'h00, 4'hF, 32'h0,        0, 1, 8'hFF, 4'h5, 32'h11223344, 0, 0, 1, 1, 8'hFF, 0, 1, 32'hAAAAAAAA};
    v[12] = '{0, 0, 8'h00, 4'hF, 32'h0,        1, 0, 8'hFF, 4'hF, 32'h0,        0, 0, 1, 0, 8'hFF, 0, 0, 32'h0};
    v[13] = '{0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 0, 0, 8'h00, 0, 1, 32'hAA22AA44};
    v[14] = '{1, 1, 8'h20, 4'hF, 32'h5,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 1, 1, 8'h20, 0, 0, 32'h0};
    v[15] = '{0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 0, 0, 8'h00, 0, 0, 32'h0};
    v[16] = '{1, 0, 8'h20, 4'hF, 32'h0,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 1, 0, 8'h20, 0, 0, 32'h0};
    v[17] = '{0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 0, 0, 8'h00, 1, 0, 32'h5};
    v[18] = '{1, 0, 8'h01, 4'hF, 32'h0,        1, 0, 8'h02, 4'hF, 32'h0,        1, 0, 1, 0, 8'h02, 0, 0, 32'h0};
    v[19] = '{0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 8'h00, 4'hF, 32'h0,        0, 0, 0, 0, 8'h00, 0, 1, 32'h22220002};

    // Reset held with requests active: everything must be quiet
    idle_inputs();
    reset_n = 1'b0;
    a_read = 1; a_address = 8'h01;
    b_write = 1; b_address = 8'h05;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", {31'b0, mem_chipselect}, 0);
    chk("rst_we", {31'b0, mem_write}, 0);
    chk("rst_clken", {31'b0, mem_clken}, 0);
    chk("rst_a_wait", {31'b0, a_waitrequest}, 1);
    chk("rst_b_wait", {31'b0, b_waitrequest}, 1);
    chk("rst_rdv", {30'b0, a_readdatavalid, b_readdatavalid}, 0);
    idle_inputs();
    reset_n = 1'b1;
    #1 chk("clken_on", {31'b0, mem_clken}, 1);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      a_read = v[i].a_rd; a_write = v[i].a_wr; a_address = v[i].a_addr;
      a_byteenable = v[i].a_be; a_writedata = v[i].a_wd;
      b_read = v[i].b_rd; b_write = v[i].b_wr; b_address = v[i].b_addr;
      b_byteenable = v[i].b_be; b_writedata = v[i].b_wd;
      @(negedge clk);
      chk($sformatf("v%0d_a_wait", i), {31'b0, a_waitrequest}, {31'b0, v[i].e_aw});
      chk($sformatf("v%0d_b_wait", i), {31'b0, b_waitrequest}, {31'b0, v[i].e_bw});
      chk($sformatf("v%0d_cs", i), {31'b0, mem_chipselect}, {31'b0, v[i].e_cs});
      chk($sformatf("v%0d_we", i), {31'b0, mem_write}, {31'b0, v[i].e_we});
      if (v[i].e_cs) chk($sformatf("v%0d_addr", i), {24'b0, mem_address}, {24'b0, v[i].e_addr});
      chk($sformatf("v%0d_a_rdv", i), {31'b0, a_readdatavalid}, {31'b0, v[i].e_ardv});
      chk($sformatf("v%0d_b_rdv", i), {31'b0, b_readdatavalid}, {31'b0, v[i].e_brdv});
      if (v[i].e_ardv) chk($sformatf("v%0d_a_rdata", i), a_readdata, v[i].e_rd);
      if (v[i].e_brdv) chk($sformatf("v%0d_b_rdata", i), b_readdata, v[i].e_rd);
    end

    // Async reset right after a granted A read: the return is dropped
    @(posedge clk);
    #1 idle_inputs(); a_read = 1; a_address = 8'h01;
    @(negedge clk);
    chk("ar_a_wait", {31'b0, a_waitrequest}, 0);
    @(posedge clk);
    #1 idle_inputs(); reset_n = 1'b0;
    #1 chk("ar_rdv_now", {31'b0, a_readdatavalid}, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("ar_hold%0d_rdv", k), {31'b0, a_readdatavalid}, 0);
      chk($sformatf("ar_hold%0d_cs", k), {31'b0, mem_chipselect}, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar_post_rdv", {30'b0, a_readdatavalid, b_readdatavalid}, 0);
    @(posedge clk);
    #1 a_read = 1; a_address = 8'h01; b_read = 1; b_address = 8'h02;
    @(negedge clk);
    chk("ar_first_a_wait", {31'b0, a_waitrequest}, 0);
    chk("ar_first_b_wait", {31'b0, b_waitrequest}, 1);
    chk("ar_first_addr", {24'b0, mem_address}, 32'h01);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk("ar_ret_a_rdv", {31'b0, a_readdatavalid}, 1);
    chk("ar_ret_a_rdata", a_readdata, 32'h11110001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
